// File: rtl/pulse_sched_pkg.sv
// Shared definitions for the pulse scheduler: state encoding and default sizes.
package pulse_sched_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_HIGH  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/pulse_sched_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first set req bit at or after ptr.
module rr_arbiter
  import pulse_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant
);

  logic [ID_W-1:0] sel;
  logic            found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel = ID_W'((int'(ptr) + i) % NREQ);
      if (!found && req[sel]) begin
        grant[sel] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pulse_sched.sv
// Shared pulse scheduler: round-robin grant, programmable delay then pulse width.
// Optional feature macro PULSE_SCHED_REPEAT_EN: owner keeps the grant and re-fires while its req stays high.
//
//   state | meaning
//   IDLE  | no owner; arbitrate when any req is set
//   DELAY | owner granted, counting delay cycles before the pulse
//   HIGH  | signal high, counting width cycles
//   DONE  | one-cycle done strobe, then IDLE (or re-fire in repeat mode)
module pulse_sched
  import pulse_sched_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int CNT_W = DEF_CNT_W,
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [NREQ-1:0]  req,
  input  logic [CNT_W-1:0] delay_cfg,
  input  logic [CNT_W-1:0] width_cfg,
  output logic [NREQ-1:0]  grant,
  output logic             signal,
  output logic             busy,
  output logic             done,
  output logic [ID_W-1:0]  done_id
);

`ifdef PULSE_SCHED_REPEAT_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  localparam bit REPEAT_EN = 1'b0;
`endif

  state_t           state;
  state_t           launch_st;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  owner;
  logic [ID_W-1:0]  arb_idx;
  logic [NREQ-1:0]  arb_gnt;
  logic [CNT_W-1:0] dcnt;
  logic [CNT_W-1:0] wcnt;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (arb_gnt)
  );

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) arb_idx = ID_W'(i);
    end
  end

  // First state of a service depends only on which counts are zero.
  always_comb begin
    if (delay_cfg != '0)      launch_st = S_DELAY;
    else if (width_cfg != '0) launch_st = S_HIGH;
    else                      launch_st = S_DONE;
  end

  function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] i);
    return (int'(i) == NREQ - 1) ? '0 : i + ID_W'(1);
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      grant   <= '0;
      signal  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
      ptr     <= '0;
      owner   <= '0;
      dcnt    <= '0;
      wcnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            grant  <= arb_gnt;
            owner  <= arb_idx;
            busy   <= 1'b1;
            state  <= launch_st;
            dcnt   <= delay_cfg;
            wcnt   <= width_cfg;
            signal <= (launch_st == S_HIGH);
            if (launch_st == S_DONE) begin
              done    <= 1'b1;
              done_id <= arb_idx;
              if (!REPEAT_EN) ptr <= next_idx(arb_idx);
            end
          end
        end
        S_DELAY: begin
          if (dcnt == CNT_W'(1)) begin
            if (wcnt != '0) begin
              state  <= S_HIGH;
              signal <= 1'b1;
            end else begin
              state   <= S_DONE;
              done    <= 1'b1;
              done_id <= owner;
              if (!REPEAT_EN) ptr <= next_idx(owner);
            end
          end else begin
            dcnt <= dcnt - CNT_W'(1);
          end
        end
        S_HIGH: begin
          if (wcnt == CNT_W'(1)) begin
            state   <= S_DONE;
            signal  <= 1'b0;
            done    <= 1'b1;
            done_id <= owner;
            if (!REPEAT_EN) ptr <= next_idx(owner);
          end else begin
            wcnt <= wcnt - CNT_W'(1);
          end
        end
        S_DONE: begin
`ifdef PULSE_SCHED_REPEAT_EN
          // Owner still requesting: re-fire with fresh config, pointer left alone.
          if (req[owner]) begin
            state  <= launch_st;
            dcnt   <= delay_cfg;
            wcnt   <= width_cfg;
            signal <= (launch_st == S_HIGH);
            if (launch_st == S_DONE) begin
              done    <= 1'b1;
              done_id <= owner;
            end
          end else begin
            state <= S_IDLE;
            grant <= '0;
            busy  <= 1'b0;
            ptr   <= next_idx(owner);
          end
`else
          state <= S_IDLE;
          grant <= '0;
          busy  <= 1'b0;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_sched.sv
// Directed bench for pulse_sched: vector table of single services plus reset, round-robin and repeat sequences.
module tb_pulse_sched;
  import pulse_sched_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] req;
  logic [7:0] delay_cfg;
  logic [7:0] width_cfg;
  logic [3:0] grant;
  logic       signal;
  logic       busy;
  logic       done;
  logic [1:0] done_id;

  int cyc  = 0;
  int nerr = 0;
  int nchk = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  pulse_sched dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .delay_cfg (delay_cfg),
    .width_cfg (width_cfg),
    .grant     (grant),
    .signal    (signal),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id)
  );

  typedef struct {
    logic [3:0] r;
    logic [7:0] d;
    logic [7:0] w;
    bit         drop;
    int         id;
    int         rise;
    int         len;
    int         doff;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int oh2i(input logic [3:0] g);
    int r = -1;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  // One service from IDLE; returns timing relative to the grant cycle G.
  task automatic service(input logic [3:0] r, input logic [7:0] d, input logic [7:0] w,
                         input bit drop, output int lat, output int gid, output int rise,
                         output int len, output int doff, output int did, output int bad,
                         output int tout);
    int t0, g;
    bit gseen;
    @(negedge clock);
    req = r; delay_cfg = d; width_cfg = w;
    t0 = cyc; g = 0; gseen = 0;
    lat = -1; gid = -1; rise = -1; len = 0; doff = -1; did = -1; bad = 0; tout = 1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clock);
      if (!gseen && grant != 4'b0) begin
        gseen = 1; g = cyc; lat = cyc - t0; gid = oh2i(grant);
        delay_cfg = 8'd7; width_cfg = 8'd9;
        if (drop) req = 4'b0;
      end
      if (gseen) begin
        if (signal) begin
          if (rise < 0) rise = cyc - g;
          len++;
        end
        if (!busy || grant != 4'(1 << gid)) bad++;
        if (done) begin
          doff = cyc - g; did = int'(done_id); req = 4'b0; tout = 0;
          break;
        end
      end
    end
    @(negedge clock);
  endtask

  initial begin
    int lat, gid, rise, len, doff, did, bad, tout;
    int n, k, seen_done, gaps;
    int ids[5];
    int tt[5];
    int exp_ids[5];
    int exp_sp, exp_per, exp_gaps;

    vecs[0] = '{4'b0001, 8'd3,   8'd2,   1'b0, 0, 3,   2,   5};
    vecs[1] = '{4'b0001, 8'd0,   8'd4,   1'b0, 0, 0,   4,   4};
    vecs[2] = '{4'b0001, 8'd5,   8'd0,   1'b0, 0, -1,  0,   5};
    vecs[3] = '{4'b0001, 8'd0,   8'd0,   1'b0, 0, -1,  0,   0};
    vecs[4] = '{4'b1100, 8'd1,   8'd1,   1'b0, 2, 1,   1,   2};
    vecs[5] = '{4'b1100, 8'd2,   8'd3,   1'b0, 3, 2,   3,   5};
    vecs[6] = '{4'b0100, 8'd2,   8'd2,   1'b1, 2, 2,   2,   4};
    vecs[7] = '{4'b0011, 8'd1,   8'd2,   1'b0, 0, 1,   2,   3};
    vecs[8] = '{4'b1010, 8'd255, 8'd255, 1'b0, 1, 255, 255, 510};

`ifdef PULSE_SCHED_REPEAT_EN
    exp_ids = '{0, 0, 0, 0, 0}; exp_sp = 3; exp_per = 6; exp_gaps = 0;
`else
    exp_ids = '{0, 1, 2, 3, 0}; exp_sp = 4; exp_per = 7; exp_gaps = 2;
`endif

    reset_n = 1'b0; req = 4'b0; delay_cfg = 8'd0; width_cfg = 8'd0;
    @(negedge clock);
    chk("rst_grant", int'(grant), 0);
    chk("rst_signal", int'(signal), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_done_id", int'(done_id), 0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("idle_busy", int'(busy), 0);

    for (int i = 0; i < 9; i++) begin
      service(vecs[i].r, vecs[i].d, vecs[i].w, vecs[i].drop, lat, gid, rise, len, doff, did, bad, tout);
      chk($sformatf("v%0d_timeout", i), tout, 0);
      chk($sformatf("v%0d_latency", i), lat, 1);
      chk($sformatf("v%0d_grant_id", i), gid, vecs[i].id);
      chk($sformatf("v%0d_rise", i), rise, vecs[i].rise);
      chk($sformatf("v%0d_width", i), len, vecs[i].len);
      chk($sformatf("v%0d_done_off", i), doff, vecs[i].doff);
      chk($sformatf("v%0d_done_id", i), did, vecs[i].id);
      chk($sformatf("v%0d_hold", i), bad, 0);
    end

    // Reset during HIGH: immediate clear, no done, arbitration restarts at 0.
    @(negedge clock);
    req = 4'b0001; delay_cfg = 8'd1; width_cfg = 8'd5;
    seen_done = 0; k = 0;
    while (!signal && k < 50) begin
      @(negedge clock);
      if (done) seen_done++;
      k++;
    end
    chk("rstmid_reached_high", int'(signal), 1);
    repeat (2) begin
      @(negedge clock);
      if (done) seen_done++;
    end
    #2 reset_n = 1'b0;
    #1;
    chk("rstmid_signal", int'(signal), 0);
    chk("rstmid_grant", int'(grant), 0);
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_no_done", seen_done + int'(done), 0);
    req = 4'b0;
    @(negedge clock);
    reset_n = 1'b1;
    service(4'b1010, 8'd0, 8'd1, 1'b0, lat, gid, rise, len, doff, did, bad, tout);
    chk("rstmid_after_id", gid, 1);
    chk("rstmid_after_done_off", doff, 1);

    // Round robin with all requests held.
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    req = 4'b1111; delay_cfg = 8'd1; width_cfg = 8'd1;
    n = 0;
    for (int j = 0; j < 200 && n < 5; j++) begin
      @(negedge clock);
      if (done) begin
        ids[n] = int'(done_id); tt[n] = cyc;
        chk($sformatf("rr_grant_at_done%0d", n), int'(grant), 1 << done_id);
        n++;
      end
    end
    chk("rr_count", n, 5);
    for (int j = 0; j < 5 && j < n; j++) chk($sformatf("rr_id%0d", j), ids[j], exp_ids[j]);
    for (int j = 1; j < 5 && j < n; j++) chk($sformatf("rr_spacing%0d", j), tt[j] - tt[j-1], exp_sp);
    req = 4'b0;
    k = 0;
    while (busy && k < 20) begin @(negedge clock); k++; end
    chk("rr_drain", int'(busy), 0);

    // Same requester held: repeat mode keeps the grant, otherwise one IDLE per period.
    @(negedge clock);
    req = 4'b0010; delay_cfg = 8'd2; width_cfg = 8'd3;
    n = 0; gaps = 0;
    for (int j = 0; j < 200 && n < 3; j++) begin
      @(negedge clock);
      if (n > 0 && grant == 4'b0) gaps++;
      if (done) begin
        tt[n] = cyc;
        chk($sformatf("rep_done_id%0d", n), int'(done_id), 1);
        n++;
      end
    end
    chk("rep_count", n, 3);
    if (n == 3) begin
      chk("rep_period1", tt[1] - tt[0], exp_per);
      chk("rep_period2", tt[2] - tt[1], exp_per);
    end
    chk("rep_grant_gaps", gaps, exp_gaps);
    req = 4'b0;
    k = 0;
    while (busy && k < 30) begin @(negedge clock); k++; end
    chk("rep_drain", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/pulse_sched.md
PULSE_SCHED -- requirements
Module: pulse_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter CNT_W, default 8, width of the delay and width counters.
REQ-003 clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  NREQ  per-requester pulse request; level, held until grant is seen.
REQ-006 delay_cfg  input  CNT_W  cycles from grant to pulse rise; sampled at grant.
REQ-007 width_cfg  input  CNT_W  pulse high time in cycles; sampled at grant.
REQ-008 grant  output  NREQ  one-hot owner of the shared pulse output; all zero when idle.
REQ-009 signal  output  1  the shared pulse.
REQ-010 busy  output  1  high in every non-IDLE state.
REQ-011 done  output  1  one-cycle strobe marking the end of a service.
REQ-012 done_id  output  $clog2(NREQ)  index of the finished requester; valid while done=1.

Function
REQ-013 FSM states: IDLE, DELAY, HIGH, DONE; state and all outputs are registered.
REQ-014 IDLE with any req bit set: grant the first set bit at or after ptr (round-robin, wrapping); latch delay_cfg and width_cfg into counters.
REQ-015 Grant cycle G is the first cycle grant is high; grant is held through DONE inclusive.
REQ-016 signal is high exactly in cycles G+delay .. G+delay+width-1.
- delay=0 -> IDLE goes directly to HIGH.
REQ-017 done=1 and done_id=owner in cycle G+delay+width (state DONE); DONE -> IDLE unconditionally.
REQ-018 width=0: no pulse; DELAY, or IDLE when delay=0, goes directly to DONE.
REQ-019 On entering DONE, ptr = owner+1 mod NREQ.
REQ-020 Minimum spacing between consecutive grants is 2 cycles (DONE, IDLE).
REQ-021 req dropping mid-service: no effect; the service runs to completion.
REQ-022 req changes outside IDLE are ignored; config changes after G are ignored.
REQ-023 Counters never wrap: max delay and width are 2^CNT_W-1 cycles each.

Reset
REQ-024 reset_n low sets immediately: state=IDLE, grant=0, signal=0, busy=0, done=0, done_id=0, ptr=0, counters=0.
REQ-025 Reset mid-service aborts without a done strobe; the first arbitration after release favours requester 0.

Configuration
REQ-026 PULSE_SCHED_REPEAT_EN defined: in DONE, if the owner's req is still high, go to DELAY (or HIGH if delay=0) with the same grant and newly sampled config.
- No IDLE cycle; ptr is not advanced; done still strobes each period.
REQ-027 PULSE_SCHED_REPEAT_EN undefined: DONE always returns to IDLE per REQ-017.

Structure
REQ-028 Shared package pulse_sched_pkg holds the state encoding (IDLE=0, DELAY=1, HIGH=2, DONE=3) and the default NREQ and CNT_W constants.
REQ-029 One sub-module, rr_arbiter: inputs req and ptr, output one-hot grant; purely combinational.
REQ-030 The FSM, counters and output registers live in pulse_sched.

Verification
REQ-031 Single request: req=4'b0001, delay=3, width=2 -> grant[0] at G; signal high G+3..G+4; done with done_id=0 at G+5.
REQ-032 Zero cases:
- delay=0, width=4 -> signal high G..G+3.
- delay=5, width=0 -> signal never high; done at G+5.
REQ-033 Round robin: req=4'b1111 held, delay=1, width=1 -> grant order 0,1,2,3,0; grants spaced 4 cycles apart.
REQ-034 Reset mid-pulse: reset_n low during HIGH -> signal=0 and grant=0 asynchronously, no done; with req=4'b1010 after release -> requester 1 granted first.
REQ-035 REPEAT_EN defined, req=4'b0010 held, delay=2, width=3 -> periodic pulses with period 6; grant[1] never drops; done every 6 cycles.
REQ-036 REPEAT_EN undefined, same stimulus -> period 7 with one IDLE cycle.
REQ-037 Req drop mid-service: req=4'b0100 dropped after G, delay=2, width=2 -> full pulse and done still produced.
